// File: rtl/sram_stall_controller_if.sv
// Bundle of MEM-stage request signals and SRAM pin signals for sram_stall_controller.
// The controller uses the slave view; the pipeline top level / bench uses the master view.
interface sram_stall_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_ce_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  modport slave (
    input  rd_en, wr_en, address, write_data, dq_in,
    output read_data, ready, sram_addr, dq_out, dq_oe,
    output sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
  );

  modport master (
    output rd_en, wr_en, address, write_data, dq_in,
    input  read_data, ready, sram_addr, dq_out, dq_oe,
    input  sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
  );
endinterface

// File: rtl/sram_stall_controller.sv
// Splits each 32-bit MEM-stage load/store into two timed 16-bit SRAM accesses,
// holding ready low (pipeline freeze) until the whole word has been transferred.
module sram_stall_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_stall_controller_if.slave bus,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [16:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req;
  logic        last;
  logic [31:0] addr_off;
  logic [15:0] half_wdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        we_n;
  logic        oe_n;

  assign req        = bus.rd_en | bus.wr_en;
  assign addr_off   = bus.address - 32'(BASE_ADDR);
  assign last       = (count_q == LAST_CNT);
  assign half_wdata = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];

  // Handshake: a request is accepted in any IDLE cycle where rd_en|wr_en is high;
  // ready is high when nothing is pending or in the single DONE cycle that
  // completes the access, and low for every LOW/HIGH cycle regardless of inputs.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    rdata_d   = rdata_q;
    ready     = 1'b0;
    sram_addr = 18'd0;
    dq_out    = 16'd0;
    dq_oe     = 1'b0;
    we_n      = 1'b1;
    oe_n      = 1'b1;
    case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) begin
          count_d = 4'd0;
          waddr_d = addr_off[18:2];
          wdata_d = bus.write_data;
          is_wr_d = bus.wr_en;
          state_d = LOW;
        end
      end
      LOW, HIGH: begin
        sram_addr = {waddr_q, state_q == HIGH};
        if (is_wr_q) begin
          dq_oe  = 1'b1;
          dq_out = half_wdata;
          we_n   = 1'b0;
        end else begin
          oe_n = 1'b0;
        end
        if (last) begin
          count_d = 4'd0;
          state_d = (state_q == HIGH) ? DONE : HIGH;
          // Sample the bus on the final cycle, once the SRAM has had the full window.
          if (!is_wr_q) begin
            if (state_q == HIGH) rdata_d[31:16] = bus.dq_in;
            else                 rdata_d[15:0]  = bus.dq_in;
          end
        end else begin
          count_d = count_q + 4'd1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      waddr_q <= 17'd0;
      wdata_q <= 32'd0;
      is_wr_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ready     = ready;
  assign bus.read_data = rdata_q;
  assign bus.sram_addr = sram_addr;
  assign bus.dq_out    = dq_out;
  assign bus.dq_oe     = dq_oe;
  assign bus.sram_we_n = we_n;
  assign bus.sram_oe_n = oe_n;
  assign bus.sram_ce_n = 1'b0;
  assign bus.sram_ub_n = 1'b0;
  assign bus.sram_lb_n = 1'b0;
  assign dbg_state_o   = state_q;

endmodule
